// File: rtl/line_clear_pkg.sv
`default_nettype none
// ============================================================================
// line_clear_pkg : playfield geometry, counter widths and FSM state encoding
// Revision: 1.0
// ============================================================================
package line_clear_pkg;

    localparam int MAP_W = 200;
    localparam int ROWS  = 20;
    localparam int COLS  = 10;
    localparam int ROW_W = 5;
    localparam int CNT_W = 5;

    localparam logic [ROW_W-1:0] ROW_LAST = 5'd19;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/line_clear_row_full.sv
`default_nettype none
// ============================================================================
// line_clear_row_full : combinational test that every column of one row is set
// Revision: 1.0
// ============================================================================
module line_clear_row_full
    import line_clear_pkg::*;
(
    input  logic [MAP_W-1:0] map_i,
    input  logic [ROW_W-1:0] row_i,
    output logic             full_o
);

    logic [COLS-1:0] w_bits;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [ROWS-1:0] w_col;
        assign w_col     = map_i[c*ROWS +: ROWS];
        assign w_bits[c] = w_col[row_i];
    end

    assign full_o = &w_bits;

endmodule
`default_nettype wire

// File: rtl/line_clear.sv
`default_nettype none
// ============================================================================
// line_clear : scans the playfield bottom-up and removes every full row
// Revision: 1.0
// ============================================================================
module line_clear
    import line_clear_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [MAP_W-1:0] map_in,
    output logic             busy,
    output logic             done,
    output logic [MAP_W-1:0] map_out,
    output logic [CNT_W-1:0] lines
);

    state_t           state_q;
    logic [MAP_W-1:0] work_q;
    logic [MAP_W-1:0] work_shift_d;
    logic [ROW_W-1:0] ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic [MAP_W-1:0] map_out_q;
    logic [CNT_W-1:0] lines_q;

    logic             w_full;
    logic [ROW_W-1:0] w_ptr_p1;
    logic [ROWS-1:0]  w_mask;

    line_clear_row_full u_row_full (
        .map_i  (work_q),
        .row_i  (ptr_q),
        .full_o (w_full)
    );

    // Mask selects rows 0..ptr; those rows take the row above, row 0 fills with zero.
    assign w_ptr_p1 = ptr_q + 5'd1;
    assign w_mask   = ~({ROWS{1'b1}} << w_ptr_p1);

    for (genvar c = 0; c < COLS; c++) begin : g_shift
        logic [ROWS-1:0] w_col;
        assign w_col = work_q[c*ROWS +: ROWS];
        assign work_shift_d[c*ROWS +: ROWS] =
            ({w_col[ROWS-2:0], 1'b0} & w_mask) | (w_col & ~w_mask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            work_q    <= '0;
            ptr_q     <= ROW_LAST;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            map_out_q <= '0;
            lines_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        work_q  <= map_in;
                        ptr_q   <= ROW_LAST;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_full) begin
                        state_q <= ST_SHIFT;
                    end else if (ptr_q != '0) begin
                        ptr_q <= ptr_q - 5'd1;
                    end else begin
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        map_out_q <= work_q;
                        lines_q   <= count_q;
                        state_q   <= ST_DONE;
                    end
                end
                // ptr is kept so a full row that just dropped into it is rescanned.
                ST_SHIFT: begin
                    work_q  <= work_shift_d;
                    count_q <= count_q + 5'd1;
                    state_q <= ST_SCAN;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign map_out = map_out_q;
    assign lines   = lines_q;

endmodule
`default_nettype wire
